// File: rtl/mdio_master_if.sv
// Command/status bundle between the management CPU side and the MDIO frame master.
interface mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_c45;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_phy;
    logic [4:0]  cmd_reg;
    logic [15:0] cmd_data;
    logic        busy;
    logic        done;
    logic [15:0] rd_data;
    logic        rd_err;

    modport master (
        output cmd_valid, cmd_c45, cmd_op, cmd_phy, cmd_reg, cmd_data,
        input  cmd_ready, busy, done, rd_data, rd_err
    );

    modport slave (
        input  cmd_valid, cmd_c45, cmd_op, cmd_phy, cmd_reg, cmd_data,
        output cmd_ready, busy, done, rd_data, rd_err
    );
endinterface

// File: rtl/mdio_master.sv
// Clause 22/45 MDIO frame master: serialises one command per frame onto MDC/MDIO, returns read data.
// Latency: busy for (PREAMBLE_LEN+32)*2*CLK_DIV cycles after handshake; cmd_ready only while idle.
module mdio_master #(
    parameter int CLK_DIV      = 4,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic   clk,
    input  logic   reset,
    mdio_master_if.slave bus,
    output logic   mdc,
    output logic   mdio_out,
    output logic   mdio_oe,
    input  logic   mdio_in
);
    localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [5:0]     PRE_LAST = 6'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA} state_t;

    state_t        state_q, state_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic          mdc_q, mdc_d;
    logic          out_q, out_d;
    logic          oe_q, oe_d;
    logic          done_q, done_d;
    logic [31:0]   tx_q, tx_d;
    logic          rd_q, rd_d;
    logic [15:0]   rx_q, rx_d;
    logic          ta_err_q, ta_err_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          rd_err_q, rd_err_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        mdc_d     = mdc_q;
        out_d     = out_q;
        oe_d      = oe_q;
        done_d    = 1'b0;
        tx_d      = tx_q;
        rd_d      = rd_q;
        rx_d      = rx_q;
        ta_err_d  = ta_err_q;
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;

        if (state_q == S_IDLE) begin
            if (bus.cmd_valid) begin
                rd_d  = bus.cmd_c45 ? bus.cmd_op[1] : (bus.cmd_op == 2'b10);
                // tx holds ST..DATA; TA is sent as 10 on writes and ignored on reads
                tx_d  = {1'b0, ~bus.cmd_c45, bus.cmd_op, bus.cmd_phy, bus.cmd_reg,
                         2'b10, bus.cmd_data};
                div_d = '0;
                mdc_d = 1'b0;
                oe_d  = 1'b1;
                if (PREAMBLE_LEN > 0) begin
                    state_d   = S_PRE;
                    bit_cnt_d = PRE_LAST;
                    out_d     = 1'b1;
                end else begin
                    state_d   = S_HDR;
                    bit_cnt_d = 6'd13;
                    out_d     = tx_d[31];
                end
            end
        end else if (div_q != DIV_MAX) begin
            div_d = div_q + 1'b1;
        end else begin
            div_d = '0;
            if (!mdc_q) begin
                mdc_d = 1'b1;
                if (state_q == S_TA && bit_cnt_q == 6'd0)
                    ta_err_d = mdio_in;
                if (state_q == S_DATA)
                    rx_d = {rx_q[14:0], mdio_in};
            end else begin
                mdc_d = 1'b0;
                if (state_q != S_PRE)
                    tx_d = {tx_q[30:0], 1'b0};
                if (bit_cnt_q != 6'd0) begin
                    bit_cnt_d = bit_cnt_q - 6'd1;
                end else begin
                    case (state_q)
                        S_PRE:  begin state_d = S_HDR;  bit_cnt_d = 6'd13; end
                        S_HDR:  begin state_d = S_TA;   bit_cnt_d = 6'd1;  end
                        S_TA:   begin state_d = S_DATA; bit_cnt_d = 6'd15; end
                        default: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            if (rd_q) begin
                                rd_data_d = rx_q;
                                rd_err_d  = ta_err_q;
                            end
                        end
                    endcase
                end
                // Pad values only ever change here, at the start of a low phase
                if (state_d == S_IDLE) begin
                    out_d = 1'b1;
                    oe_d  = 1'b0;
                end else if (state_d == S_PRE) begin
                    out_d = 1'b1;
                    oe_d  = 1'b1;
                end else begin
                    out_d = tx_d[31];
                    oe_d  = (state_d == S_HDR) || !rd_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            div_q     <= '0;
            mdc_q     <= 1'b0;
            out_q     <= 1'b1;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            tx_q      <= '0;
            rd_q      <= 1'b0;
            rx_q      <= '0;
            ta_err_q  <= 1'b0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            mdc_q     <= mdc_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            done_q    <= done_d;
            tx_q      <= tx_d;
            rd_q      <= rd_d;
            rx_q      <= rx_d;
            ta_err_q  <= ta_err_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_err    = rd_err_q;
    assign mdc           = mdc_q;
    assign mdio_out      = out_q;
    assign mdio_oe       = oe_q;
endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: two instances (CLK_DIV=2/PRE=32 and CLK_DIV=1/PRE=0) with a bit-level PHY model.
module tb_mdio_master;
    logic clk = 1'b0;
    logic rst_n;
    logic mdio_in;
    logic sel;

    logic        c_valid, c_c45;
    logic [1:0]  c_op;
    logic [4:0]  c_phy, c_reg;
    logic [15:0] c_data;

    mdio_master_if if0();
    mdio_master_if if1();
    logic mdc0, out0, oe0, mdc1, out1, oe1;

    assign if0.cmd_valid = c_valid & ~sel;
    assign if0.cmd_c45   = c_c45;
    assign if0.cmd_op    = c_op;
    assign if0.cmd_phy   = c_phy;
    assign if0.cmd_reg   = c_reg;
    assign if0.cmd_data  = c_data;
    assign if1.cmd_valid = c_valid & sel;
    assign if1.cmd_c45   = c_c45;
    assign if1.cmd_op    = c_op;
    assign if1.cmd_phy   = c_phy;
    assign if1.cmd_reg   = c_reg;
    assign if1.cmd_data  = c_data;

    mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) dut0 (
        .clk(clk), .reset(rst_n), .bus(if0.slave),
        .mdc(mdc0), .mdio_out(out0), .mdio_oe(oe0), .mdio_in(mdio_in)
    );
    mdio_master #(.CLK_DIV(1), .PREAMBLE_LEN(0)) dut1 (
        .clk(clk), .reset(rst_n), .bus(if1.slave),
        .mdc(mdc1), .mdio_out(out1), .mdio_oe(oe1), .mdio_in(mdio_in)
    );

    logic        m_ready, m_busy, m_done, m_mdc, m_out, m_oe, m_err;
    logic [15:0] m_rd;
    assign m_ready = sel ? if1.cmd_ready : if0.cmd_ready;
    assign m_busy  = sel ? if1.busy      : if0.busy;
    assign m_done  = sel ? if1.done      : if0.done;
    assign m_rd    = sel ? if1.rd_data   : if0.rd_data;
    assign m_err   = sel ? if1.rd_err    : if0.rd_err;
    assign m_mdc   = sel ? mdc1 : mdc0;
    assign m_out   = sel ? out1 : out0;
    assign m_oe    = sel ? oe1  : oe0;

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] f_stream, f_oe;
    int          f_busy, f_waits;
    logic [15:0] f_rd;
    logic        f_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame on the selected instance; cmd = {c45, op, phy, reg, data}.
    // rsp gives the PHY's mdio_in value for each post-preamble bit, MSB first.
    task automatic run_frame(input logic [28:0] cmd, input bit keep, input logic [28:0] nxt,
                             input logic [31:0] rsp, input int abort_bit);
        int k, busy_cnt, pre, n;
        logic [63:0] s, o;
        logic pm;
        bit fin;
        pre = sel ? 0 : 32;
        n   = pre + 32;
        {c_c45, c_op, c_phy, c_reg, c_data} = cmd;
        c_valid = 1'b1;
        f_waits = 0;
        while (!m_ready && f_waits < 100) begin
            @(negedge clk);
            f_waits++;
        end
        chk("hs_ready", 64'(m_ready), 64'd1);
        @(posedge clk);
        #1;
        if (keep) {c_c45, c_op, c_phy, c_reg, c_data} = nxt;
        else c_valid = 1'b0;
        @(negedge clk);
        chk("busy_rise", 64'(m_busy), 64'd1);
        k = 0; busy_cnt = 0; s = '0; o = '0; pm = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (m_done) begin
                fin = 1'b1;
                chk("done_busy", 64'(m_busy), 64'd0);
                chk("done_ready", 64'(m_ready), 64'd1);
                chk("done_mdc", 64'(m_mdc), 64'd0);
                chk("done_oe", 64'(m_oe), 64'd0);
                f_rd  = m_rd;
                f_err = m_err;
            end else begin
                if (m_busy) busy_cnt++;
                if (!pm && m_mdc) begin
                    s = {s[62:0], m_out};
                    o = {o[62:0], m_oe};
                    k++;
                end
                pm = m_mdc;
                mdio_in = (k < pre || k >= n) ? 1'b1 : rsp[31 - (k - pre)];
                if (abort_bit > 0 && k == abort_bit) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_mdc", 64'(m_mdc), 64'd0);
                    chk("abort_oe", 64'(m_oe), 64'd0);
                    chk("abort_busy", 64'(m_busy), 64'd0);
                    chk("abort_rd_data", 64'(m_rd), 64'd0);
                    chk("abort_rd_err", 64'(m_err), 64'd0);
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        chk("abort_no_done", 64'(m_done), 64'd0);
                    end
                    mdio_in = 1'b1;
                    rst_n   = 1'b1;
                    @(negedge clk);
                    return;
                end
            end
        end
        chk("done_seen", 64'(fin), 64'd1);
        mdio_in  = 1'b1;
        f_stream = s;
        f_oe     = o;
        f_busy   = busy_cnt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; c_valid = 1'b0; c_c45 = 1'b0; c_op = '0; c_phy = '0; c_reg = '0; c_data = '0;
        mdio_in = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(m_ready), 64'd1);
        chk("rst_busy", 64'(m_busy), 64'd0);
        chk("rst_done", 64'(m_done), 64'd0);
        chk("rst_mdc", 64'(m_mdc), 64'd0);
        chk("rst_oe", 64'(m_oe), 64'd0);
        chk("rst_out", 64'(m_out), 64'd1);
        chk("rst_rd_data", 64'(m_rd), 64'd0);
        chk("rst_rd_err", 64'(m_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: C22 write phy 1 reg 0 data 1140
        run_frame({1'b0, 2'b01, 5'h01, 5'h00, 16'h1140}, 1'b0, '0, 32'hFFFF_FFFF, 0);
        chk("t1_stream", f_stream, {32'hFFFF_FFFF, 32'h5082_1140});
        chk("t1_oe", f_oe, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_busy", 64'(f_busy), 64'd256);
        chk("t1_rd_data", 64'(f_rd), 64'd0);
        chk("t1_rd_err", 64'(f_err), 64'd0);
        @(negedge clk);
        chk("t1_single_done", 64'(m_done), 64'd0);

        // 2: C22 read phy 3 reg 2, PHY returns 0141 with good TA
        run_frame({1'b0, 2'b10, 5'h03, 5'h02, 16'h0000}, 1'b0, '0, {14'h3FFF, 2'b10, 16'h0141}, 0);
        chk("t2_hdr", 64'(f_stream[63:18]), 64'({32'hFFFF_FFFF, 14'b01100001100010}));
        chk("t2_oe", f_oe, 64'hFFFF_FFFF_FFFC_0000);
        chk("t2_busy", 64'(f_busy), 64'd256);
        chk("t2_rd_data", 64'(f_rd), 64'h0141);
        chk("t2_rd_err", 64'(f_err), 64'd0);

        // 3: read with nobody driving, then a write that must not disturb the result
        run_frame({1'b0, 2'b10, 5'h03, 5'h02, 16'h0000}, 1'b0, '0, 32'hFFFF_FFFF, 0);
        chk("t3_rd_data", 64'(f_rd), 64'hFFFF);
        chk("t3_rd_err", 64'(f_err), 64'd1);
        run_frame({1'b0, 2'b01, 5'h1F, 5'h1F, 16'hA5A5}, 1'b0, '0, 32'hFFFF_FFFF, 0);
        chk("t3w_stream", f_stream, {32'hFFFF_FFFF, 32'h5FFE_A5A5});
        chk("t3w_rd_data", 64'(f_rd), 64'hFFFF);
        chk("t3w_rd_err", 64'(f_err), 64'd1);

        // 4: C45 address then back-to-back C45 read
        run_frame({1'b1, 2'b00, 5'h02, 5'h01, 16'h0800}, 1'b1,
                  {1'b1, 2'b11, 5'h02, 5'h01, 16'h0000}, 32'hFFFF_FFFF, 0);
        chk("t4a_stream", f_stream, {32'hFFFF_FFFF, 32'h0106_0800});
        chk("t4a_oe", f_oe, 64'hFFFF_FFFF_FFFF_FFFF);
        run_frame({1'b1, 2'b11, 5'h02, 5'h01, 16'h0000}, 1'b0, '0, {14'h3FFF, 2'b10, 16'hBEEF}, 0);
        chk("t4b_b2b_accept", 64'(f_waits), 64'd0);
        chk("t4b_hdr", 64'(f_stream[63:18]), 64'({32'hFFFF_FFFF, 14'b00110001000001}));
        chk("t4b_rd_data", 64'(f_rd), 64'hBEEF);
        chk("t4b_rd_err", 64'(f_err), 64'd0);

        // 5: no preamble, CLK_DIV=1 instance
        sel = 1'b1;
        @(negedge clk);
        run_frame({1'b0, 2'b01, 5'h01, 5'h00, 16'h1140}, 1'b0, '0, 32'hFFFF_FFFF, 0);
        chk("t5_stream", f_stream, {32'h0, 32'h5082_1140});
        chk("t5_oe", f_oe, 64'h0000_0000_FFFF_FFFF);
        chk("t5_busy", 64'(f_busy), 64'd64);
        sel = 1'b0;
        @(negedge clk);

        // 6: reset during the DATA phase of a read, then a clean write
        run_frame({1'b0, 2'b10, 5'h03, 5'h02, 16'h0000}, 1'b0, '0, {14'h3FFF, 2'b10, 16'h1234}, 53);
        run_frame({1'b0, 2'b01, 5'h05, 5'h04, 16'h8000}, 1'b0, '0, 32'hFFFF_FFFF, 0);
        chk("t6_stream", f_stream, {32'hFFFF_FFFF, 32'h5292_8000});
        chk("t6_busy", 64'(f_busy), 64'd256);
        chk("t6_rd_data", 64'(f_rd), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
